// File: rtl/entry_code_encoder_pkg.sv
// entry_code_encoder shared definitions
// state encoding, code width, button polarity
package entry_code_encoder_pkg;

  localparam int CODE_W = 3;

  // raw and debounced buttons read 0 when pressed
  localparam logic BTN_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_FEAT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  typedef logic [CODE_W-1:0] code_t;

  // digit edit step, 7 wraps to 0
  function automatic code_t code_inc(input code_t c);
    return c + code_t'(1);
  endfunction

endpackage

// File: rtl/entry_code_encoder_if.sv
// entry_code_encoder request bus
// master = encoder, slave = permission/conflict logic
interface entry_code_encoder_if;
  import entry_code_encoder_pkg::*;

  logic  req_valid;
  code_t req_addr;
  code_t req_feat;
  logic  ack;

  modport master (
    output req_valid,
    output req_addr,
    output req_feat,
    input  ack
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_feat,
    output ack
  );

endinterface

// File: rtl/entry_code_encoder_button_debouncer.sv
// button_debouncer: sync, stability filter,
// one-cycle press pulse on released->pressed
module button_debouncer #(
  parameter int DEB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_n,
  output logic o_press
);
  import entry_code_encoder_pkg::*;

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic          r_deb_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // sync, count stable mismatches, flip level, edge-detect press
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= ~BTN_ACTIVE;
      r_sync2 <= ~BTN_ACTIVE;
      r_deb   <= ~BTN_ACTIVE;
      r_deb_d <= ~BTN_ACTIVE;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      r_press <= (r_deb_d != BTN_ACTIVE) &&
                 (r_deb == BTN_ACTIVE);
      if (r_sync2 != r_deb) begin
        if (r_cnt == C_LAST) begin
          r_deb <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/entry_code_encoder.sv
// entry_code_encoder: button entry of address
// then feature code, presented over valid/ack
module entry_code_encoder
  import entry_code_encoder_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_bt_inc,
  input  logic                 i_bt_ent,
  input  logic                 i_bt_clr,
  entry_code_encoder_if.master bus,
  output logic [CODE_W-1:0]    o_cur_digit,
  output logic [1:0]           o_state_out,
  output logic                 o_timeout_flag
);

  localparam bit TEN = (TIMEOUT != 0);
  localparam int TW  = TEN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST =
    TW'(TEN ? TIMEOUT - 1 : 0);

  logic w_p_inc;
  logic w_p_ent;
  logic w_p_clr;
  logic w_any;
  logic w_inc;
  logic w_ent;
  logic w_clr;
  logic w_counting;
  logic w_timeout;

  state_e        r_state;
  code_t         r_digit;
  code_t         r_addr;
  code_t         r_feat;
  logic          r_valid;
  logic          r_tflag;
  logic [TW-1:0] r_tcnt;

  button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_btn_n (i_bt_inc),
    .o_press (w_p_inc)
  );

  button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ent (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_btn_n (i_bt_ent),
    .o_press (w_p_ent)
  );

  button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_btn_n (i_bt_clr),
    .o_press (w_p_clr)
  );

  // same-cycle presses: CLR beats ENT beats INC
  assign w_any = w_p_inc | w_p_ent | w_p_clr;
  assign w_clr = w_p_clr;
  assign w_ent = w_p_ent & ~w_p_clr;
  assign w_inc = w_p_inc & ~w_p_ent & ~w_p_clr;

  // a press in the expiry cycle wins over the timeout
  assign w_counting = (r_state == ST_ADDR) ||
                      (r_state == ST_FEAT);
  assign w_timeout  = TEN && w_counting && !w_any &&
                      (r_tcnt == T_LAST);

  // entry FSM with digit, request and timeout registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_digit <= '0;
      r_addr  <= '0;
      r_feat  <= '0;
      r_valid <= 1'b0;
      r_tflag <= 1'b0;
      r_tcnt  <= '0;
    end else begin
      r_tflag <= 1'b0;
      if (!TEN || !w_counting || w_any || w_timeout) begin
        r_tcnt <= '0;
      end else begin
        r_tcnt <= r_tcnt + TW'(1);
      end
      unique case (r_state)
        ST_IDLE: begin
          if (w_ent || w_inc) begin
            r_state <= ST_ADDR;
            r_digit <= '0;
          end
        end
        ST_ADDR: begin
          if (w_clr) begin
            r_state <= ST_IDLE;
            r_digit <= '0;
          end else if (w_ent) begin
            r_addr  <= r_digit;
            r_digit <= '0;
            r_state <= ST_FEAT;
          end else if (w_inc) begin
            r_digit <= code_inc(r_digit);
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
            r_digit <= '0;
            r_tflag <= 1'b1;
          end
        end
        ST_FEAT: begin
          if (w_clr) begin
            r_state <= ST_IDLE;
            r_digit <= '0;
          end else if (w_ent) begin
            r_feat  <= r_digit;
            r_valid <= 1'b1;
            r_state <= ST_HOLD;
          end else if (w_inc) begin
            r_digit <= code_inc(r_digit);
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
            r_digit <= '0;
            r_tflag <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (bus.ack) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_valid   = r_valid;
  assign bus.req_addr    = r_addr;
  assign bus.req_feat    = r_feat;
  assign o_cur_digit     = r_digit;
  assign o_state_out     = r_state;
  assign o_timeout_flag  = r_tflag;

endmodule

// File: tb/tb_entry_code_encoder.sv
// entry_code_encoder directed bench
// u_dut: TIMEOUT=20, u_dut0: TIMEOUT=0, shared inputs
module tb_entry_code_encoder;

  localparam logic [2:0] INC = 3'b001;
  localparam logic [2:0] ENT = 3'b010;
  localparam logic [2:0] CLR = 3'b100;

  logic       r_clk = 1'b0;
  logic       r_rst = 1'b1;
  logic [2:0] r_btn = 3'b111;
  logic       r_ack = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  logic [2:0] w_dig;
  logic [1:0] w_st;
  logic       w_tf;
  logic [2:0] w_dig0;
  logic [1:0] w_st0;
  logic       w_tf0;

  entry_code_encoder_if u_if ();
  entry_code_encoder_if u_if0 ();

  assign u_if.ack  = r_ack;
  assign u_if0.ack = r_ack;

  always #5 r_clk = ~r_clk;

  entry_code_encoder #(
    .DEB_CYCLES (4),
    .TIMEOUT    (20)
  ) u_dut (
    .i_clk          (r_clk),
    .i_rst          (r_rst),
    .i_bt_inc       (r_btn[0]),
    .i_bt_ent       (r_btn[1]),
    .i_bt_clr       (r_btn[2]),
    .bus            (u_if),
    .o_cur_digit    (w_dig),
    .o_state_out    (w_st),
    .o_timeout_flag (w_tf)
  );

  entry_code_encoder #(
    .DEB_CYCLES (4),
    .TIMEOUT    (0)
  ) u_dut0 (
    .i_clk          (r_clk),
    .i_rst          (r_rst),
    .i_bt_inc       (r_btn[0]),
    .i_bt_ent       (r_btn[1]),
    .i_bt_clr       (r_btn[2]),
    .bus            (u_if0),
    .o_cur_digit    (w_dig0),
    .o_state_out    (w_st0),
    .o_timeout_flag (w_tf0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge r_clk);
  endtask

  task automatic hit(input logic [2:0] m);
    r_btn = ~m;
    tick(8);
    r_btn = 3'b111;
    tick(8);
  endtask

  task automatic do_reset();
    r_rst = 1'b1;
    tick(2);
    r_rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    tick(3);
    // reset values
    chk("rst_valid", u_if.req_valid, 0);
    chk("rst_addr", u_if.req_addr, 0);
    chk("rst_feat", u_if.req_feat, 0);
    chk("rst_digit", w_dig, 0);
    chk("rst_state", w_st, 0);
    chk("rst_tflag", w_tf, 0);
    r_rst = 1'b0;
    tick(1);

    // full entry: addr 5, feat 2
    hit(ENT);
    chk("fe_addr_st", w_st, 1);
    chk("fe_addr_dig", w_dig, 0);
    repeat (5) hit(INC);
    chk("fe_dig5", w_dig, 5);
    hit(ENT);
    chk("fe_feat_st", w_st, 2);
    chk("fe_addr5", u_if.req_addr, 5);
    chk("fe_dig0", w_dig, 0);
    chk("fe_nvalid", u_if.req_valid, 0);
    repeat (2) hit(INC);
    hit(ENT);
    chk("fe_hold_st", w_st, 3);
    chk("fe_valid", u_if.req_valid, 1);
    chk("fe_req_addr", u_if.req_addr, 5);
    chk("fe_req_feat", u_if.req_feat, 2);
    tick(20);
    chk("fe_hold_st2", w_st, 3);
    chk("fe_valid2", u_if.req_valid, 1);
    r_ack = 1'b1;
    tick(1);
    r_ack = 1'b0;
    chk("fe_ack_valid", u_if.req_valid, 0);
    chk("fe_ack_st", w_st, 0);
    chk("fe_keep_addr", u_if.req_addr, 5);
    chk("fe_keep_feat", u_if.req_feat, 2);

    // debounce, wrap, priority on the no-timeout unit
    do_reset();
    hit(ENT);
    chk("db_addr_st", w_st0, 1);
    r_btn = ~INC;
    tick(2);
    r_btn = 3'b111;
    tick(8);
    chk("db_glitch", w_dig0, 0);
    r_btn = ~INC;
    tick(6);
    chk("db_lat_n5", w_dig0, 0);
    tick(1);
    chk("db_lat_n6", w_dig0, 0);
    tick(1);
    chk("db_lat_n7", w_dig0, 1);
    r_btn = 3'b111;
    tick(8);
    chk("db_once", w_dig0, 1);
    repeat (8) hit(INC);
    chk("wrap_dig1", w_dig0, 1);
    repeat (2) hit(INC);
    chk("pri_dig3", w_dig0, 3);
    hit(INC | ENT);
    chk("pri_st", w_st0, 2);
    chk("pri_addr", u_if0.req_addr, 3);
    chk("pri_dig", w_dig0, 0);
    hit(CLR | ENT);
    chk("clr_st", w_st0, 0);
    chk("clr_valid", u_if0.req_valid, 0);
    chk("clr_addr", u_if0.req_addr, 3);

    // timeout after 20 idle cycles in ADDR
    do_reset();
    r_btn = ~ENT;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick(1);
      if (w_st == 2'd1) found = 1'b1;
    end
    r_btn = 3'b111;
    chk("to_entered", found, 1);
    tick(19);
    chk("to_st19", w_st, 1);
    chk("to_flag19", w_tf, 0);
    tick(1);
    chk("to_st20", w_st, 0);
    chk("to_flag20", w_tf, 1);
    tick(1);
    chk("to_flag21", w_tf, 0);
    tick(1000);
    chk("to0_st", w_st0, 1);
    chk("to0_flag", w_tf0, 0);

    // HOLD ignores buttons until ack
    do_reset();
    hit(ENT);
    hit(INC);
    hit(ENT);
    repeat (3) hit(INC);
    hit(ENT);
    chk("hd_valid0", u_if.req_valid, 1);
    hit(CLR);
    hit(INC);
    hit(ENT);
    tick(2);
    chk("hd_valid", u_if.req_valid, 1);
    chk("hd_addr", u_if.req_addr, 1);
    chk("hd_feat", u_if.req_feat, 3);
    chk("hd_st", w_st, 3);

    // single reset edge drops the pending request
    r_rst = 1'b1;
    tick(1);
    r_rst = 1'b0;
    chk("rh_valid", u_if.req_valid, 0);
    chk("rh_addr", u_if.req_addr, 0);
    chk("rh_feat", u_if.req_feat, 0);
    chk("rh_st", w_st, 0);
    chk("rh_dig", w_dig, 0);

    // ENT held through reset gives one press
    r_btn = ~ENT;
    r_rst = 1'b1;
    tick(3);
    r_rst = 1'b0;
    tick(7);
    chk("hr_st_n6", w_st, 0);
    tick(1);
    chk("hr_st_n7", w_st, 1);
    r_btn = 3'b111;
    tick(10);
    chk("hr_once_st", w_st, 1);
    chk("hr_once_dig", w_dig, 0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/entry_code_encoder.md
Name: entry_code_encoder

Overview:
- Sequential front end for one entry interface. Turns raw active-low push buttons into a 3-bit interface address followed by a 3-bit feature code.
- Presents the finished pair to the permission/priority/conflict logic over a valid/ack handshake. This replaces direct switch wiring of address and feature bits.
- One instance per entry interface (IE01, IE02).
- CUR_DIGIT feeds the seven-segment path during entry.

Parameters:
- DEB_CYCLES, 4: consecutive stable synchronized samples required before a debounced level changes (min 1).
- TIMEOUT, 255: cycles without a press event in ADDR/FEAT before entry is abandoned. 0 disables the timeout.

Ports:
- CLK  input  1  system clock
- RST  input  1  reset: synchronous, active-high
- BT_INC  input  1  raw button, active-low: increment current digit
- BT_ENT  input  1  raw button, active-low: commit current digit
- BT_CLR  input  1  raw button, active-low: abandon entry
- ACK  input  1  consumer accepts request; sampled only in HOLD
- REQ_VALID  output  1  request pair available
- REQ_ADDR  output  3  committed interface address
- REQ_FEAT  output  3  committed feature code
- CUR_DIGIT  output  3  digit currently being edited
- STATE_OUT  output  2  IDLE=0, ADDR=1, FEAT=2, HOLD=3
- TIMEOUT_FLAG  output  1  one-cycle pulse on timeout abandon

Behaviour:
- Reset (RST high at a CLK edge):
  - State is IDLE; all outputs are 0.
  - Debounced levels are set to released (1); synchronizers are set to 1; all counters are 0.
  - A button held across reset yields one press event after the normal debounce latency.
- Per-button conditioning:
  - Two-flop synchronizer feeds a stability counter.
  - When the synchronized value differs from the debounced level, the counter increments; otherwise it clears.
  - When the counter would reach DEB_CYCLES, the debounced level takes the synchronized value and the counter clears.
  - A press event is a one-cycle pulse in the cycle after the debounced level goes released to pressed.
  - Latency: if raw goes low before edge N and stays low, the press pulse is high in the cycle after edge N+DEB_CYCLES+2.
  - Release produces no event. A glitch shorter than DEB_CYCLES synchronized cycles produces no event.
- Priority of press events arriving in the same cycle: CLR > ENT > INC. Lower-priority events in that cycle are discarded.
- FSM transitions:
  - IDLE: INC or ENT press -> ADDR, CUR_DIGIT=0; the press is consumed and does not edit. CLR press: no effect.
  - ADDR: INC -> CUR_DIGIT+1 mod 8 (7 wraps to 0). ENT -> REQ_ADDR<=CUR_DIGIT, CUR_DIGIT<=0, -> FEAT. CLR -> IDLE, CUR_DIGIT<=0.
  - FEAT: INC as in ADDR. ENT -> REQ_FEAT<=CUR_DIGIT, REQ_VALID<=1, -> HOLD. CLR -> IDLE, CUR_DIGIT<=0, REQ_ADDR unchanged.
  - HOLD: REQ_VALID=1; REQ_ADDR/REQ_FEAT are held stable. All button events are ignored, including CLR: valid never drops without ack. ACK high at an edge -> IDLE, with REQ_VALID=0 from the next cycle. REQ_ADDR/REQ_FEAT keep their last values.
- Handshake:
  - REQ_VALID rises only on the FEAT ENT commit.
  - Minimum valid duration is 1 cycle (ACK may already be high when REQ_VALID rises; the transfer completes on the next edge).
  - ACK outside HOLD is ignored.
- Timeout:
  - Idle counter runs only in ADDR/FEAT and clears on any press event or state change.
  - When it reaches TIMEOUT: -> IDLE, CUR_DIGIT<=0, TIMEOUT_FLAG high for exactly 1 cycle.
  - A press event in the same cycle as the timeout takes priority; no timeout occurs that cycle.
  - Counter width is clog2(TIMEOUT+1).
- Reset mid-operation (any state, including HOLD): immediately returns to reset values; a pending request is dropped.

Decomposition:
- Shared package: state encoding constants (IDLE/ADDR/FEAT/HOLD), CODE_W=3, and the button-active level constant (0 = pressed). The allpermission/featureconflictchecker side uses the same CODE_W.
- Sub-module button_debouncer (params DEB_CYCLES): synchronizer, stability counter, debounced level, press pulse. Instantiated three times.
- FSM, digit register, timeout counter and output registers stay in entry_code_encoder.

Test Plan (DEB_CYCLES=4, TIMEOUT=20 unless stated):
- Full entry: ENT, INC x5, ENT, INC x2, ENT, ACK held low -> REQ_VALID=1, REQ_ADDR=5, REQ_FEAT=2, STATE_OUT=3 held; ACK high one edge -> REQ_VALID=0 next cycle, STATE_OUT=0.
- Debounce: 2-cycle low glitch on BT_INC in ADDR -> CUR_DIGIT unchanged. Steady low from edge N -> press pulse in the cycle after edge N+6, CUR_DIGIT increments once.
- Wrap and priority:
  - INC x9 in ADDR -> CUR_DIGIT=1.
  - INC and ENT debounced in same cycle with CUR_DIGIT=3 -> REQ_ADDR=3, state FEAT, CUR_DIGIT=0.
  - CLR+ENT simultaneous in FEAT -> IDLE, REQ_VALID stays 0.
- Timeout: enter ADDR, no presses for 20 cycles -> STATE_OUT=0, TIMEOUT_FLAG high exactly 1 cycle. With TIMEOUT=0, idle for 1000 cycles -> stays in ADDR.
- HOLD robustness: in HOLD, press CLR, INC, ENT with ACK=0 -> REQ_VALID, REQ_ADDR, REQ_FEAT unchanged for 50 cycles.
- Reset:
  - RST high one edge while in HOLD -> next cycle all outputs 0, STATE_OUT=0.
  - BT_ENT held low through reset -> exactly one press event after DEB_CYCLES+3 edges, state ADDR.
